// File: rtl/looper_pkg.sv
// Shared types and helpers for the looper sequencing controller.
package looper_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECORD   = 2'd1,
    PLAYBACK = 2'd2
  } state_t;

  localparam int SAT_W = 24;

  // Fixed-width saturating add for the standard 24-bit sample path.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b
  );
    logic signed [SAT_W:0] s;
    s = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    if (s[SAT_W] != s[SAT_W-1])
      return s[SAT_W] ? {1'b1, {(SAT_W-1){1'b0}}} : {1'b0, {(SAT_W-1){1'b1}}};
    return s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/looper_ctrl_if.sv
// Single-port loop RAM bus; the controller is master, the RAM is slave.
interface looper_ctrl_if #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_re;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (output mem_addr, mem_we, mem_wdata, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_we, mem_wdata, mem_re, output mem_rdata);
endinterface

// File: rtl/looper_ctrl.sv
// Looper sequencer: footswitch press detection, IDLE/RECORD/PLAYBACK control,
// loop RAM access and saturating mix of the loop over the live input.
module looper_ctrl
  import looper_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 48000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [WIDTH-1:0]  in_signal,
  input  logic                     btn,
  output logic signed [WIDTH-1:0]  out_signal,
  output logic                     out_valid,
  looper_ctrl_if.master            mem_bus,
  output logic [1:0]               state_o,
  output logic [ADDR_W:0]          loop_len
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W+1)'(DEPTH);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        ptr_q, ptr_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic                     btn_q, btn_d;
  logic signed [WIDTH-1:0]  in_reg_q, in_reg_d;
  logic                     play_q, play_d;
  logic                     out_valid_q, out_valid_d;

  logic                     press;
  logic [ADDR_W:0]          rec_cnt;
  logic                     do_wr, do_rd;
  logic signed [WIDTH:0]    sum;
  logic signed [WIDTH-1:0]  mix;

  always_comb begin
    press   = btn & ~btn_q;
    rec_cnt = {1'b0, ptr_q} + {{ADDR_W{1'b0}}, sample_valid};
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d = RECORD;
          ptr_d   = '0;
        end
      end
      RECORD: begin
        // Auto-stop outranks a coincident press; a sample in the press cycle counts.
        if (sample_valid && (ptr_q == LAST_ADDR)) begin
          state_d = PLAYBACK;
          len_d   = FULL_LEN;
          ptr_d   = '0;
        end else if (press) begin
          ptr_d = '0;
          if (rec_cnt != '0) begin
            state_d = PLAYBACK;
            len_d   = rec_cnt;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ptr_d = rec_cnt[ADDR_W-1:0];
        end
      end
      PLAYBACK: begin
        if (sample_valid)
          ptr_d = ({1'b0, ptr_q} == (len_q - (ADDR_W+1)'(1))) ? '0 : ptr_q + ADDR_W'(1);
        if (press) begin
          state_d = IDLE;
          len_d   = '0;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
        len_d   = '0;
      end
    endcase
  end

  always_comb begin
    btn_d       = btn;
    out_valid_d = sample_valid;
    in_reg_d    = in_reg_q;
    play_d      = play_q;
    if (sample_valid) begin
      in_reg_d = in_signal;
      play_d   = (state_q == PLAYBACK);
    end
  end

  // Gated by rst so no RAM access escapes during a reset cycle.
  always_comb begin
    do_wr              = ~rst & sample_valid & (state_q == RECORD);
    do_rd              = ~rst & sample_valid & (state_q == PLAYBACK);
    mem_bus.mem_we     = do_wr;
    mem_bus.mem_re     = do_rd;
    mem_bus.mem_addr   = (do_wr | do_rd) ? ptr_q : '0;
    mem_bus.mem_wdata  = do_wr ? in_signal : '0;
  end

  always_comb begin
    sum = {in_reg_q[WIDTH-1], in_reg_q} + {mem_bus.mem_rdata[WIDTH-1], mem_bus.mem_rdata};
    mix = sum[WIDTH-1:0];
    if (sum[WIDTH] != sum[WIDTH-1])
      mix = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    out_signal = '0;
    if (out_valid_q)
      out_signal = play_q ? mix : in_reg_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      btn_q       <= 1'b0;
      in_reg_q    <= '0;
      play_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      btn_q       <= btn_d;
      in_reg_q    <= in_reg_d;
      play_q      <= play_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign state_o   = state_q;
  assign loop_len  = len_q;

endmodule

// File: tb/tb_looper_ctrl.sv
// Randomised and directed bench for looper_ctrl against a behavioural looper model.
module tb_looper_ctrl;

  localparam int W     = 24;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic [W-1:0]  in_signal;
  logic          btn;
  logic [W-1:0]  out_signal;
  logic          out_valid;
  logic [1:0]    state_o;
  logic [AW:0]   loop_len;

  looper_ctrl_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  looper_ctrl #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .in_signal    (in_signal),
    .btn          (btn),
    .out_signal   (out_signal),
    .out_valid    (out_valid),
    .mem_bus      (bus.master),
    .state_o      (state_o),
    .loop_len     (loop_len)
  );

  always #5 clk = ~clk;

  // External loop RAM: single port, one-cycle read latency.
  logic [W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: the loop is an array of recorded samples plus a play index.
  int           m_st  = 0;   // 0 idle, 1 recording, 2 playing
  int           m_ptr = 0;
  int           m_len = 0;
  bit           m_btn = 0;
  logic [W-1:0] m_loop [DEPTH];
  bit           exp_ov;
  logic [W-1:0] exp_out;

  function automatic logic [W-1:0] sat24(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 8388607)  s = 8388607;
    if (s < -8388608) s = -8388608;
    return s[W-1:0];
  endfunction

  task automatic step(input bit sv, input logic [W-1:0] d, input bit b, input bit r);
    bit press, e_we, e_re;
    int cnt;
    @(negedge clk);
    sample_valid = sv; in_signal = d; btn = b; rst = r;
    #1;
    press = b && !m_btn;
    e_we  = !r && sv && (m_st == 1);
    e_re  = !r && sv && (m_st == 2);
    check("mem_we", bus.mem_we, e_we);
    check("mem_re", bus.mem_re, e_re);
    check("mem_addr", bus.mem_addr, (e_we || e_re) ? m_ptr : 0);
    check("mem_wdata", bus.mem_wdata, e_we ? d : '0);
    if (r) begin
      m_st = 0; m_ptr = 0; m_len = 0; m_btn = 0;
      exp_ov = 0; exp_out = '0;
    end else begin
      exp_ov  = sv;
      exp_out = !sv ? '0 : (m_st == 2) ? sat24(d, m_loop[m_ptr]) : d;
      if (e_we) m_loop[m_ptr] = d;
      case (m_st)
        0: if (press) begin m_st = 1; m_ptr = 0; end
        1: begin
          cnt = m_ptr + int'(sv);
          if (sv && cnt == DEPTH) begin m_st = 2; m_len = DEPTH; m_ptr = 0; end
          else if (press) begin
            m_st = (cnt > 0) ? 2 : 0; m_len = cnt; m_ptr = 0;
          end else m_ptr = cnt;
        end
        default: begin
          if (sv) m_ptr = (m_ptr + 1) % m_len;
          if (press) begin m_st = 0; m_len = 0; m_ptr = 0; end
        end
      endcase
      m_btn = b;
    end
    @(posedge clk);
    #1;
    check("state", state_o, m_st);
    check("loop_len", loop_len, m_len);
    check("out_valid", out_valid, exp_ov);
    check("out_signal", out_signal, exp_out);
  endtask

  task automatic sample(input logic [W-1:0] d);
    step(1, d, 0, 0);
    step(0, '0, 0, 0);
  endtask

  task automatic press_release();
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);
  endtask

  initial begin
    bit b, sv, prev_sv, r;
    logic [W-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; m_loop[i] = '0; end
    sample_valid = 0; in_signal = '0; btn = 0; rst = 1;
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);

    // Record 10..50 then close the loop by press.
    press_release();
    for (int i = 1; i <= 5; i++) sample(W'(i * 10));
    step(0, '0, 1, 0);
    check("t1_state", state_o, 2);
    check("t1_len", loop_len, 5);
    step(0, '0, 0, 0);

    // Play back over a constant input of 1 (wraps at the loop end).
    for (int i = 0; i < 12; i++) sample(W'(1));
    press_release();

    // Fill the RAM; press coincides with the auto-stop write.
    press_release();
    for (int i = 1; i <= 7; i++) sample(W'(i));
    step(1, W'(80), 1, 0);
    check("t3_state", state_o, 2);
    check("t3_len", loop_len, DEPTH);
    step(0, '0, 0, 0);

    // Saturation at both rails.
    press_release();
    press_release();
    sample(24'h000100);
    sample(24'hFFFF00);
    press_release();
    step(1, 24'h7FFFF0, 0, 0);
    check("sat_pos", out_signal, 24'h7FFFFF);
    step(0, '0, 0, 0);
    step(1, 24'h800010, 0, 0);
    check("sat_neg", out_signal, 24'h800000);
    step(0, '0, 0, 0);
    press_release();

    // Press-press with no sample, then a long hold.
    press_release();
    press_release();
    check("t5_len", loop_len, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 1, 0);
    check("t5_hold", state_o, 1);
    step(0, '0, 0, 0);
    press_release();

    // Reset mid-record with a coincident sample, then record again.
    press_release();
    for (int i = 0; i < 3; i++) sample(W'(100 + i));
    step(1, W'(99), 0, 1);
    check("t6_state", state_o, 0);
    step(0, '0, 0, 0);
    press_release();
    sample(W'(5));
    press_release();
    sample(W'(7));
    press_release();

    // Random traffic.
    b = 0; prev_sv = 0;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 11) == 0) b = ~b;
      sv = !prev_sv && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: d = {16'h7FFF, 8'($urandom)};
        1: d = {16'h8000, 8'($urandom)};
        default: d = W'($urandom);
      endcase
      step(sv, d, b, r);
      prev_sv = sv;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/looper_ctrl.md
Name: looper_ctrl

Overview:
Sequencing controller for the guitar looper. It turns a footswitch level into press events and runs the IDLE/RECORD/PLAYBACK sequence. It drives a single-port synchronous loop RAM (address, write enable, read enable) and mixes the recorded loop over the live input with saturation. It sits between the effect chain's sample stream and an external loop RAM with a fixed 1-cycle read latency.

Parameters:
WIDTH, 24, signed sample width
DEPTH, 48000, loop RAM depth in samples (1 s at 48 kHz); maximum loop length
ADDR_W, $clog2(DEPTH), RAM address width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_valid  in  1  one-cycle strobe, new in_signal sample; spacing at least 2 cycles
in_signal  in  WIDTH  signed live sample, valid with sample_valid
btn  in  1  debounced, synchronised footswitch level
out_signal  out  WIDTH  signed mixed output sample
out_valid  out  1  one-cycle strobe, out_signal valid
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  WIDTH  RAM write data
mem_re  out  1  RAM read enable; mem_rdata valid the following cycle
mem_rdata  in  WIDTH  RAM read data
state_o  out  2  current state (IDLE=0, RECORD=1, PLAYBACK=2)
loop_len  out  ADDR_W+1  committed loop length in samples; 0 means no loop

Behaviour:
- Reset: state IDLE; ptr=0; loop_len=0; btn_q=0; out_signal=0; out_valid=0; mem_we=0; mem_re=0; mem_addr=0; mem_wdata=0. RAM contents are not cleared.
- Press detect: press = btn & ~btn_q, where btn_q is btn registered. A held button gives exactly one press.
- Memory outputs are combinational from state, ptr and sample_valid, asserted only in the sample_valid cycle.
- IDLE:
  - on sample_valid: no RAM access; output is in_signal.
  - press: go to RECORD, ptr<=0.
- RECORD:
  - on sample_valid: mem_we=1, mem_addr=ptr, mem_wdata=in_signal, ptr<=ptr+1; output is in_signal.
  - press with ptr>0: go to PLAYBACK, loop_len<=ptr, ptr<=0.
  - press with ptr==0: go to IDLE, loop_len stays 0.
  - auto-stop: the write that makes ptr+1==DEPTH forces PLAYBACK next cycle, loop_len<=DEPTH, ptr<=0, without a press.
- PLAYBACK:
  - on sample_valid: mem_re=1, mem_addr=ptr; ptr<=(ptr==loop_len-1)?0:ptr+1.
  - press: go to IDLE, loop_len<=0, ptr<=0.
- Output pipeline: fixed latency of 1 cycle in every state. in_signal is registered at sample_valid. The following cycle out_valid=1 with:
  - out_signal = in_reg in IDLE/RECORD.
  - out_signal = sat(in_reg + mem_rdata) in PLAYBACK.
  - Selection uses the state latched with the sample, not the current state.
- Saturation: sum computed at WIDTH+1 bits, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Press coinciding with sample_valid: the sample is processed under the current state (write or read performed), then the transition takes effect.
  - RECORD: that sample is included in loop_len.
- Press coinciding with auto-stop: auto-stop wins and the state goes to PLAYBACK; the press is consumed.
- Reset mid-RECORD or mid-PLAYBACK: returns to IDLE, loop_len=0, and no write or read is issued in the reset cycle.

Decomposition:
- Package looper_pkg:
  - state_t enum {IDLE, RECORD, PLAYBACK} (2-bit)
  - function sat_add(a, b) returning WIDTH-bit saturated sum; width passed via a parameterised class or a fixed 24-bit version plus the WIDTH generic in the module
- No further sub-module needed; loop RAM is external (loop_ram, single-port, 1-cycle read) and instantiated by the parent.

Test Plan:
Bench uses DEPTH=8, WIDTH=24.
1. Press, 5 samples 10..50, press → mem_we at addr 0..4 with data 10..50; loop_len=5, state PLAYBACK; out equals input in RECORD with 1-cycle latency.
2. PLAYBACK with input 1 for 12 samples, RAM model → mem_addr sequence 0,1,2,3,4,0,1,2,3,4,0,1; out_signal 11,21,31,41,51,11,...
3. Record 8 samples without a second press → after the 8th write the state auto-switches to PLAYBACK, loop_len=8; a press in that same cycle leaves the state in PLAYBACK.
4. PLAYBACK with in=0x7FFFF0 and rdata=0x000100 → out=0x7FFFFF; with in=0x800010 and rdata=0xFFFF00 → out=0x800000.
5. Press-press with no sample between → state back to IDLE, loop_len=0, no mem_we; btn held high for 20 cycles → exactly one transition.
6. rst asserted mid-RECORD at ptr=3 → next cycle state IDLE, loop_len=0, mem_we=0, out_valid=0; a subsequent record starts at addr 0.
